// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmit path.
//
// Contents:
//   UART_DATA_BITS            - number of data bits per frame (fixed at 8)
//   UART_CLKS_PER_BIT_DEFAULT - default bit period in clocks (100 MHz / 115200)
//   tx_state_t                - transmitter frame-sequencing states
package uart_pkg;

    localparam int UART_DATA_BITS            = 8;
    localparam int UART_CLKS_PER_BIT_DEFAULT = 868;

    // Explicit 3-bit encoding so the state can be exported on a debug port
    // and compared against plain vectors by external checkers.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// uart_tx_ctrl_if: byte handshake between a host-side byte source and the
// UART transmit controller.
//
// Signals:
//   tx_data  [7:0] byte offered by the source
//   tx_valid       source has a byte on tx_data
//   tx_ready       controller can accept a byte this cycle
//
// Handshake: a byte is transferred on a rising clock edge where tx_valid and
// tx_ready are both high. tx_data is only meaningful while tx_valid is high
// and is sampled exactly once, on that edge. tx_valid while tx_ready is low
// has no effect; the source may keep it high to queue the next byte.
//
// Modports:
//   master - the byte source (drives tx_data/tx_valid)
//   slave  - the transmit controller (drives tx_ready)
interface uart_tx_ctrl_if;
    import uart_pkg::*;

    logic [UART_DATA_BITS-1:0] tx_data;
    logic                      tx_valid;
    logic                      tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );

endinterface

// File: rtl/uart_parity_calc.sv
// uart_parity_calc: combinational parity generator for one UART data byte.
//
// Ports:
//   data   [7:0] byte being framed
//   odd          0 = even parity, 1 = odd parity
//   parity       parity bit to place on the line after the data bits
//
// Even parity makes the total number of ones in data+parity even, which is
// simply the XOR of the data bits; odd parity is its inverse.
module uart_parity_calc
    import uart_pkg::*;
(
    input  logic [UART_DATA_BITS-1:0] data,
    input  logic                      odd,
    output logic                      parity
);

    assign parity = (^data) ^ odd;

endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART transmit controller.
//
// Accepts a byte over the tx_if handshake, latches its parity, and
// serialises start bit, 8 data bits (LSB first), an optional parity bit and
// a stop bit onto tx_out, each held for CLKS_PER_BIT clocks.
//
// Parameters:
//   CLKS_PER_BIT  clocks per UART bit, >= 2
//   PARITY_EN     1 = 11-bit frame with parity, 0 = 10-bit frame
//   PARITY_ODD    0 = even parity, 1 = odd parity
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   tx_if      byte handshake (slave side): tx_data, tx_valid, tx_ready
//   tx_out     serial line, idle high (registered)
//   busy       frame in progress (registered)
//   done       one-cycle pulse on the last cycle of the stop bit (registered)
//   state_dbg  current FSM state, for observation only
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
    parameter bit PARITY_EN    = 1'b1,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    uart_tx_ctrl_if.slave  tx_if,
    output logic           tx_out,
    output logic           busy,
    output logic           done,
    output tx_state_t      state_dbg
);

    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        BIT_LAST  = 3'(UART_DATA_BITS - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    tx_state_t                 state_q,  state_d;
    logic [BAUD_W-1:0]         baud_q,   baud_d;
    logic [2:0]                bit_q,    bit_d;
    logic [UART_DATA_BITS-1:0] shift_q,  shift_d;
    logic                      parity_q, parity_d;
    logic                      tx_out_q, tx_out_d;
    logic                      busy_q,   busy_d;
    logic                      done_q,   done_d;

    logic                      parity_w;
    logic                      baud_end;

    // Parity is computed from the live bus but only captured together with
    // the byte, so later tx_data changes cannot disturb the frame in flight.
    uart_parity_calc u_parity (
        .data   (tx_if.tx_data),
        .odd    (PARITY_ODD),
        .parity (parity_w)
    );

    assign baud_end = (baud_q == BAUD_LAST);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        parity_d = parity_q;

        case (state_q)
            IDLE: begin
                if (tx_if.tx_valid) begin
                    shift_d  = tx_if.tx_data;
                    parity_d = parity_w;
                    baud_d   = '0;
                    bit_d    = '0;
                    state_d  = START;
                end
            end

            START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            DATA: begin
                if (baud_end) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = PARITY_EN ? PARITY : STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            PARITY: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = STOP;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            STOP: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = IDLE;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            default: begin
                baud_d  = '0;
                bit_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------
    // The outputs are decoded from the *next* state so that, once
    // registered, they line up with the state they describe: tx_out goes
    // low on the first START cycle and done lands on the last STOP cycle.
    always_comb begin
        case (state_d)
            IDLE:    tx_out_d = 1'b1;
            START:   tx_out_d = 1'b0;
            DATA:    tx_out_d = shift_d[0];
            PARITY:  tx_out_d = parity_d;
            STOP:    tx_out_d = 1'b1;
            default: tx_out_d = 1'b1;
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == STOP) && (baud_d == BAUD_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            tx_out_q <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            tx_out_q <= tx_out_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Ready is combinational on rst so that a byte offered in the same
    // cycle as reset is never considered transferred.
    assign tx_if.tx_ready = (state_q == IDLE) && !rst;

    assign tx_out    = tx_out_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: bench for uart_tx_ctrl.
//
// Three controllers (even parity, odd parity, no parity; 4 clocks per bit)
// share one stimulus stream. Each has its own frame-level model: a byte
// accepted while idle becomes a frame of line bits, each held CPB cycles.
`timescale 1ns/1ps
module tb_uart_tx_ctrl;
    import uart_pkg::*;

    localparam int       CPB = 4;
    // index 0 = even parity, 1 = odd parity, 2 = no parity
    localparam bit [2:0] PE  = 3'b011;
    localparam bit [2:0] PO  = 3'b010;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] data_r;
    logic       valid_r;

    uart_tx_ctrl_if if_e ();
    uart_tx_ctrl_if if_o ();
    uart_tx_ctrl_if if_n ();

    assign if_e.tx_data  = data_r;
    assign if_e.tx_valid = valid_r;
    assign if_o.tx_data  = data_r;
    assign if_o.tx_valid = valid_r;
    assign if_n.tx_data  = data_r;
    assign if_n.tx_valid = valid_r;

    logic [2:0] tx_out_v, busy_v, done_v, ready_v;
    tx_state_t  st_e, st_o, st_n;

    assign ready_v = {if_n.tx_ready, if_o.tx_ready, if_e.tx_ready};

    uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_e (
        .clk       (clk),
        .rst       (rst),
        .tx_if     (if_e),
        .tx_out    (tx_out_v[0]),
        .busy      (busy_v[0]),
        .done      (done_v[0]),
        .state_dbg (st_e)
    );

    uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) dut_o (
        .clk       (clk),
        .rst       (rst),
        .tx_if     (if_o),
        .tx_out    (tx_out_v[1]),
        .busy      (busy_v[1]),
        .done      (done_v[1]),
        .state_dbg (st_o)
    );

    uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut_n (
        .clk       (clk),
        .rst       (rst),
        .tx_if     (if_n),
        .tx_out    (tx_out_v[2]),
        .busy      (busy_v[2]),
        .done      (done_v[2]),
        .state_dbg (st_n)
    );

    // ------------------------------------------------------------------
    // Reference model: frame contents + position within the frame
    // ------------------------------------------------------------------
    bit          m_act [3];
    int          m_ev  [3];
    int          m_len [3];
    logic [10:0] m_fr  [3];

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    // Frame bit k goes on the line during slot k: start, d0..d7, then
    // parity+stop or just stop.
    function automatic logic [10:0] build_frame(input logic [7:0] d, input bit pe, input bit po);
        logic p;
        p = (($countones(d) % 2) == 1) ^ po;
        if (pe) return {1'b1, p, d, 1'b0};
        else    return {1'b1, 1'b1, d, 1'b0};
    endfunction

    task automatic model_edge();
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                m_act[d] = 1'b0;
            end else if (m_act[d]) begin
                m_ev[d] = m_ev[d] + 1;
                if (m_ev[d] == m_len[d] * CPB) m_act[d] = 1'b0;
            end else if (valid_r) begin
                m_act[d] = 1'b1;
                m_ev[d]  = 0;
                m_len[d] = PE[d] ? 11 : 10;
                m_fr[d]  = build_frame(data_r, PE[d], PO[d]);
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk = n_chk + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic compare_all();
        logic e_tx;
        for (int d = 0; d < 3; d++) begin
            e_tx = m_act[d] ? m_fr[d][m_ev[d] / CPB] : 1'b1;
            check($sformatf("tx_out[%0d]", d), 32'(tx_out_v[d]), 32'(e_tx));
            check($sformatf("busy[%0d]", d),   32'(busy_v[d]),   32'(m_act[d]));
            check($sformatf("done[%0d]", d),   32'(done_v[d]),
                  32'(m_act[d] && (m_ev[d] == m_len[d] * CPB - 1)));
            check($sformatf("ready[%0d]", d),  32'(ready_v[d]),  32'(!m_act[d] && !rst));
        end
    endtask

    // One clock: model advances with the edge, outputs sampled mid-cycle.
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cyc = cyc + 1;
        compare_all();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((m_act[0] || m_act[1] || m_act[2] || busy_v != 3'b000) && n < 300) begin
            tick();
            n = n + 1;
        end
        check("idle_bound", 32'(busy_v), 32'd0);
    endtask

    // ------------------------------------------------------------------
    // Directed + random stimulus
    // ------------------------------------------------------------------
    logic [10:0] a5_slots;

    initial begin
        a5_slots = 11'b10101001010;   // 0, 1,0,1,0,0,1,0,1, 0, 1
        rst     = 1'b1;
        valid_r = 1'b0;
        data_r  = 8'h00;
        for (int d = 0; d < 3; d++) begin
            m_act[d] = 1'b0;
            m_ev[d]  = 0;
            m_len[d] = 11;
            m_fr[d]  = '1;
        end

        // Reset
        repeat (3) tick();
        check("reset_state_e", 32'(st_e), 32'(IDLE));
        check("reset_state_o", 32'(st_o), 32'(IDLE));
        check("reset_state_n", 32'(st_n), 32'(IDLE));
        rst = 1'b0;
        tick();
        check("ready_after_rst", 32'(ready_v), 32'h7);
        tick();

        // 8'hA5, even parity: exact line pattern, done at cycle 44
        data_r  = 8'hA5;
        valid_r = 1'b1;
        for (int i = 0; i < 44; i++) begin
            tick();
            valid_r = 1'b0;
            if (i % CPB == 1) check("a5_line", 32'(tx_out_v[0]), 32'(a5_slots[i / CPB]));
            check("a5_done", 32'(done_v[0]), 32'(i == 43));
            check("a5_ready_low", 32'(ready_v[0]), 32'd0);
        end
        tick();
        check("a5_ready_after", 32'(ready_v[0]), 32'd1);
        wait_idle();

        // 8'h01: odd parity bit 0, even parity bit 1
        data_r  = 8'h01;
        valid_r = 1'b1;
        for (int i = 0; i < 44; i++) begin
            tick();
            valid_r = 1'b0;
            if (i == 37) begin
                check("par_odd_01",  32'(tx_out_v[1]), 32'd0);
                check("par_even_01", 32'(tx_out_v[0]), 32'd1);
            end
        end
        wait_idle();

        // 8'hFF without parity: 40-cycle frame
        data_r  = 8'hFF;
        valid_r = 1'b1;
        for (int i = 0; i < 44; i++) begin
            tick();
            valid_r = 1'b0;
            check("nopar_done", 32'(done_v[2]), 32'(i == 39));
            if (i == 37) check("nopar_stop", 32'(tx_out_v[2]), 32'd1);
            if (i == 40) check("nopar_idle", 32'(ready_v[2]), 32'd1);
        end
        wait_idle();

        // Back-to-back with tx_valid held: 3C then C3
        data_r  = 8'h3C;
        valid_r = 1'b1;
        for (int i = 0; i < 46; i++) begin
            tick();
            if (i == 0)  data_r = 8'hC3;
            if (i == 43) check("b2b_done", 32'(done_v[0]), 32'd1);
            if (i == 44) begin
                check("b2b_gap_line",  32'(tx_out_v[0]), 32'd1);
                check("b2b_gap_ready", 32'(ready_v[0]), 32'd1);
            end
            if (i == 45) begin
                check("b2b_start_line", 32'(tx_out_v[0]), 32'd0);
                check("b2b_start_busy", 32'(busy_v[0]), 32'd1);
            end
        end
        valid_r = 1'b0;
        wait_idle();

        // tx_valid pulse mid-frame is ignored
        data_r  = 8'h96;
        valid_r = 1'b1;
        tick();
        valid_r = 1'b0;
        repeat (10) tick();
        data_r  = 8'h55;
        valid_r = 1'b1;
        tick();
        valid_r = 1'b0;
        wait_idle();
        repeat (4) tick();
        check("no_extra_frame", 32'(busy_v), 32'd0);

        // Reset during data bit 3, with tx_valid also high (reset wins)
        data_r  = 8'hB7;
        valid_r = 1'b1;
        tick();
        valid_r = 1'b0;
        repeat (17) tick();
        rst     = 1'b1;
        valid_r = 1'b1;
        data_r  = 8'h42;
        tick();
        check("rst_line", 32'(tx_out_v), 32'h7);
        check("rst_busy", 32'(busy_v), 32'h0);
        check("rst_done", 32'(done_v), 32'h0);
        rst     = 1'b0;
        valid_r = 1'b0;
        tick();
        check("rst_ready", 32'(ready_v), 32'h7);
        data_r  = 8'h0F;
        valid_r = 1'b1;
        tick();
        valid_r = 1'b0;
        wait_idle();

        // Random traffic, occasional resets
        for (int i = 0; i < 1500; i++) begin
            rst     = ($urandom_range(0, 299) == 0);
            valid_r = ($urandom_range(0, 3) == 0);
            data_r  = 8'($urandom);
            tick();
        end
        rst     = 1'b0;
        valid_r = 1'b0;
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
